rst_seq_ctrl: RTL

Reset sequencer for a multi-domain chip region: holds every downstream reset domain in reset, then releases them one at a time in fixed index order. Between releases it waits a programmable delay plus a per-domain ready acknowledge. It sits upstream of the per-domain reset synchronizers, with one registered active-low reset output per domain. A synchronous software request restarts the full sequence, and an acknowledge timeout is reported as an error.

---
 rtl/rst_seq_ctrl_if.sv | 27 ++
 rtl/rst_seq_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle for the reset sequencer.
// Slave side is the sequencer, master side is its environment.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOM = 4,
  parameter int DLY_W   = 8
) ();
  localparam int SW = $clog2(NUM_DOM);

  logic               sw_rst_req_i;
  logic [DLY_W-1:0]   dly_i;
  logic [NUM_DOM-1:0] dom_ack_i;
  logic [NUM_DOM-1:0] rst_n_o;
  logic [SW-1:0]      stage_o;
  logic               busy_o;
  logic               done_o;
  logic               err_o;

  modport slave (
    input  sw_rst_req_i, dly_i, dom_ack_i,
    output rst_n_o, stage_o, busy_o, done_o, err_o
  );

  modport master (
    output sw_rst_req_i, dly_i, dom_ack_i,
    input  rst_n_o, stage_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, then releases
// them in index order, gated by a delay and a per-domain ack.
module rst_seq_ctrl #(
  parameter int NUM_DOM  = 4,
  parameter int DLY_W    = 8,
  parameter int DLY_DEF  = 16,
  parameter int HOLD_CYC = 4,
  parameter int ACK_TO   = 256
) (
  input logic          clk_i,
  input logic          rst_i,
  rst_seq_ctrl_if.slave bus
);
  localparam int IW   = $clog2(NUM_DOM);
  localparam int MAXA = (HOLD_CYC > ACK_TO) ? HOLD_CYC : ACK_TO;
  localparam int MAXD = 1 << DLY_W;
  localparam int MAXC = (MAXA > MAXD) ? MAXA : MAXD;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] ACK_M1  = CW'(ACK_TO - 1);
  localparam logic [IW-1:0] LAST    = IW'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    S_ASSERT,
    S_WAIT_DLY,
    S_WAIT_ACK,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state, w_state;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic [IW-1:0]      r_idx, w_idx;
  logic [DLY_W-1:0]   r_dly, w_dly;
  logic [NUM_DOM-1:0] r_rst_n, w_rst_n;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_err, w_err;
  logic               w_dly_hit;

  assign w_dly_hit = (r_cnt == {{(CW-DLY_W){1'b0}}, r_dly});

  // State register: sequencing state, counter, index, delay, resets
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dly   <= DLY_W'(DLY_DEF);
      r_rst_n <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_dly   <= w_dly;
      r_rst_n <= w_rst_n;
    end
  end

  // Next-state logic; a software request overrides everything
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_dly   = r_dly;
    w_rst_n = r_rst_n;
    if (bus.sw_rst_req_i) begin
      w_state = S_ASSERT;
      w_cnt   = '0;
      w_idx   = '0;
      w_rst_n = '0;
    end else begin
      unique case (r_state)
        S_ASSERT: begin
          w_dly   = bus.dly_i;
          w_rst_n = '0;
          if (r_cnt == HOLD_M1) begin
            w_state = S_WAIT_DLY;
            w_cnt   = '0;
            w_idx   = '0;
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
        S_WAIT_DLY: begin
          if (w_dly_hit) begin
            w_rst_n[r_idx] = 1'b1;
            w_state        = S_WAIT_ACK;
            w_cnt          = '0;
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
        S_WAIT_ACK: begin
          if (bus.dom_ack_i[r_idx]) begin
            w_cnt = '0;
            if (r_idx == LAST) begin
              w_state = S_DONE;
            end else begin
              w_idx   = r_idx + IW'(1);
              w_state = S_WAIT_DLY;
            end
          end else if (r_cnt == ACK_M1) begin
            w_state = S_ERR;
          end else begin
            w_cnt = r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          w_rst_n = '1;
        end
        S_ERR: begin
          w_state = S_ERR;
        end
        default: begin
          w_state = S_ASSERT;
          w_cnt   = '0;
          w_idx   = '0;
          w_rst_n = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so status flops track it
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    w_err  = 1'b0;
    unique case (w_state)
      S_ASSERT, S_WAIT_DLY, S_WAIT_ACK: w_busy = 1'b1;
      S_DONE:                           w_done = 1'b1;
      S_ERR:                            w_err  = 1'b1;
      default:                          w_busy = 1'b1;
    endcase
  end

  // Status flops keep the outputs glitch-free
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy;
      r_done <= w_done;
      r_err  <= w_err;
    end
  end

  assign bus.rst_n_o = r_rst_n;
  assign bus.stage_o = r_idx;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;
  assign bus.err_o   = r_err;
endmodule
